mdu_unit: RTL and testbench

- Multiply/divide unit in the E stage of the pipelined MIPS core; sits beside the ALU and consumes the same forwarded operands A1/A2.
- Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and owns the architectural HI/LO registers.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Drives Start/Busy to the hazard unit so later MDU instructions stall until HI/LO are committed.

---
 rtl/mdu_unit_if.sv | 14 +
 rtl/mdu_unit.sv | 93 +++++++++
 tb/tb_mdu_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mdu_unit_if.sv
// mdu_unit_if: E-stage operand, opcode and HI/LO result bundle between the pipeline and the multiply/divide unit
interface mdu_unit_if;
    logic [31:0] A1;
    logic [31:0] A2;
    logic [3:0]  MDUOp;
    logic        Req;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] O;
    modport master (output A1, A2, MDUOp, Req, input Start, Busy, HI, LO, O);
    modport slave  (input A1, A2, MDUOp, Req, output Start, Busy, HI, LO, O);
endinterface

// File: rtl/mdu_unit.sv
// mdu_unit: fixed-latency MULT/MULTU/DIV/DIVU engine owning architectural HI/LO, with MFHI/MFLO/MTHI/MTLO
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_unit_if.slave  bus
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [31:0]   hi, lo, sh_hi, sh_lo;
    logic          sh_wr;
    logic          is_mul, is_div, div_s, mul_s, commit, mthi, mtlo, div_ovf, div_zero;
    logic [63:0]   ma, mb, prod;
    logic [31:0]   a_mag, b_mag, b_safe, uq, ur, quo, rem;
    assign is_mul   = bus.MDUOp == 4'd1 || bus.MDUOp == 4'd2;
    assign is_div   = bus.MDUOp == 4'd3 || bus.MDUOp == 4'd4;
    assign mul_s    = bus.MDUOp == 4'd1;
    assign div_s    = bus.MDUOp == 4'd3;
    assign div_zero = bus.A2 == 32'd0;
    assign bus.Start = (is_mul || is_div) && state == IDLE && !bus.Req;
    assign bus.Busy  = state == RUN;
    assign mthi   = bus.MDUOp == 4'd7 && state == IDLE && !bus.Req;
    assign mtlo   = bus.MDUOp == 4'd8 && state == IDLE && !bus.Req;
    assign commit = state == RUN && cnt == CW'(1);
    assign bus.HI = hi;
    assign bus.LO = lo;
    assign bus.O  = bus.MDUOp == 4'd5 ? hi : bus.MDUOp == 4'd6 ? lo : 32'd0;
    // One 64x64 multiplier: signedness is folded into the operand extension
    always_comb begin
        ma   = {{32{mul_s & bus.A1[31]}}, bus.A1};
        mb   = {{32{mul_s & bus.A2[31]}}, bus.A2};
        prod = ma * mb;
    end
    // Signed divide runs on magnitudes; the zero-divisor path is forced to 1 so no X/trap is produced
    always_comb begin
        a_mag   = div_s && bus.A1[31] ? -bus.A1 : bus.A1;
        b_mag   = div_s && bus.A2[31] ? -bus.A2 : bus.A2;
        b_safe  = b_mag == 32'd0 ? 32'd1 : b_mag;
        uq      = a_mag / b_safe;
        ur      = a_mag % b_safe;
        div_ovf = div_s && bus.A1 == 32'h8000_0000 && bus.A2 == 32'hFFFF_FFFF;
        quo     = div_ovf ? 32'h8000_0000 : div_s && (bus.A1[31] ^ bus.A2[31]) ? -uq : uq;
        rem     = div_ovf ? 32'd0 : div_s && bus.A1[31] ? -ur : ur;
    end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (bus.Start) begin
            state_nx = RUN;
            cnt_nx   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (commit) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (state == RUN) begin
            cnt_nx   = cnt - 1'b1;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi    <= '0;
            lo    <= '0;
            sh_hi <= '0;
            sh_lo <= '0;
            sh_wr <= 1'b0;
        end else begin
            if (bus.Start) begin
                sh_hi <= is_mul ? prod[63:32] : rem;
                sh_lo <= is_mul ? prod[31:0] : quo;
                sh_wr <= !(is_div && div_zero);
            end
            if (commit && sh_wr) begin
                hi <= sh_hi;
                lo <= sh_lo;
            end
            if (mthi) hi <= bus.A1;
            if (mtlo) lo <= bus.A1;
        end
    end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed and random checks of mdu_unit against an arithmetic HI/LO reference model
module tb_mdu_unit;
    logic clk;
    logic reset;
    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;
    mdu_unit_if bus();
    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));
    initial clk = 0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // Reference: architectural results straight from 64-bit integer arithmetic
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd3: if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            4'd7: m_hi = a;
            4'd8: m_lo = a;
            default: ;
        endcase
    endtask
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] bop, input logic breq);
        int n;
        n = (op == 4'd1 || op == 4'd2) ? 5 : 10;
        bus.MDUOp = op; bus.A1 = a; bus.A2 = b; bus.Req = 0;
        #1 chk("start", 32'(bus.Start), 32'd1);
        @(posedge clk); #1;
        bus.MDUOp = bop; bus.Req = breq; bus.A1 = $urandom; bus.A2 = $urandom;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("busy", 32'(bus.Busy), 32'd1);
            chk("start_busy", 32'(bus.Start), 32'd0);
            chk("hi_hold", bus.HI, m_hi);
            chk("lo_hold", bus.LO, m_lo);
            @(posedge clk); #1;
        end
        bus.MDUOp = 0; bus.Req = 0;
        model(op, a, b);
        #1;
        chk("busy_fall", 32'(bus.Busy), 32'd0);
        chk("hi", bus.HI, m_hi);
        chk("lo", bus.LO, m_lo);
    endtask
    task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic req);
        bus.MDUOp = op; bus.A1 = a; bus.Req = req;
        #1 chk("mt_start", 32'(bus.Start), 32'd0);
        @(posedge clk); #1;
        bus.MDUOp = 0; bus.Req = 0;
        if (!req) model(op, a, 32'd0);
        chk("mt_busy", 32'(bus.Busy), 32'd0);
        chk("mt_hi", bus.HI, m_hi);
        chk("mt_lo", bus.LO, m_lo);
    endtask
    task automatic mf();
        bus.MDUOp = 4'd5;
        #1 chk("mfhi", bus.O, m_hi);
        bus.MDUOp = 4'd6;
        #1 chk("mflo", bus.O, m_lo);
        bus.MDUOp = 4'd0;
        #1 chk("o_none", bus.O, 32'd0);
    endtask
    initial begin
        logic [3:0] ops [6];
        logic [3:0] op;
        logic [31:0] a, b;
        ops[0] = 1; ops[1] = 2; ops[2] = 3; ops[3] = 4; ops[4] = 7; ops[5] = 8;
        reset = 1; bus.A1 = 0; bus.A2 = 0; bus.MDUOp = 0; bus.Req = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        chk("rst_o", bus.O, 32'd0);
        reset = 0;
        issue(4'd1, 32'hFFFF_FFFE, 32'h0000_0003, 4'd0, 1'b0);
        mf();
        issue(4'd2, 32'hFFFF_FFFE, 32'h0000_0003, 4'd0, 1'b0);
        mf();
        issue(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 4'd0, 1'b0);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'd0, 1'b0);
        mf();
        mt(4'd7, 32'h1234_5678, 1'b0);
        issue(4'd4, 32'd7, 32'd0, 4'd8, 1'b0);
        mf();
        bus.MDUOp = 4'd1; bus.A1 = 32'd9; bus.A2 = 32'd9; bus.Req = 1;
        #1 chk("req_start", 32'(bus.Start), 32'd0);
        @(posedge clk); #1;
        bus.MDUOp = 0; bus.Req = 0;
        chk("req_busy", 32'(bus.Busy), 32'd0);
        chk("req_hi", bus.HI, m_hi);
        chk("req_lo", bus.LO, m_lo);
        mt(4'd8, 32'hDEAD_BEEF, 1'b1);
        issue(4'd3, 32'd1000, 32'hFFFF_FFF9, 4'd3, 1'b1);
        for (int k = 0; k < 30; k++) begin
            op = ops[$urandom_range(0, 5)];
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 20)));
            if (op == 4'd7 || op == 4'd8) mt(op, a, 1'b0);
            else issue(op, a, b, 4'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
            mf();
        end
        mt(4'd7, 32'hA5A5_0001, 1'b0);
        mt(4'd8, 32'h5A5A_0002, 1'b0);
        bus.MDUOp = 4'd1; bus.A1 = 32'd5; bus.A2 = 32'd7;
        @(posedge clk); #1;
        bus.MDUOp = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        m_hi = 0; m_lo = 0;
        #1;
        chk("arst_busy", 32'(bus.Busy), 32'd0);
        chk("arst_hi", bus.HI, 32'd0);
        chk("arst_lo", bus.LO, 32'd0);
        @(posedge clk); #1 reset = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("post_busy", 32'(bus.Busy), 32'd0);
        chk("post_hi", bus.HI, 32'd0);
        chk("post_lo", bus.LO, 32'd0);
        reset = 1; bus.MDUOp = 4'd1; bus.A1 = 32'd3; bus.A2 = 32'd4;
        @(posedge clk); #1;
        reset = 0; bus.MDUOp = 0;
        #1 chk("rst_start_busy", 32'(bus.Busy), 32'd0);
        repeat (7) @(posedge clk);
        #1;
        chk("rst_start_hi", bus.HI, 32'd0);
        chk("rst_start_lo", bus.LO, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
